// File: rtl/pid_multi_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pid_multi_axis                                               |
// | Description : Time-multiplexed PID rate controller for N_AXES axes sharing |
// |               one arithmetic datapath. Per-axis runtime gains (fixed       |
// |               point, GAIN_FRAC fraction bits), clamped integrator and      |
// |               saturated outputs.                                           |
// | Ports       : us_clk, resetn (async, active-low)                           |
// |               start, clear_integ       - run / integrator clear (IDLE)     |
// |               target_rate, actual_rate - packed signed rates, axis 0 LSBs  |
// |               kp, ki, kd               - packed signed per-axis gains      |
// |               rate_out, sat_flags      - results, updated with done        |
// |               busy, done               - run status / completion pulse     |
// | Options     : `define PID_ANTIWINDUP_EN holds the integrator while the     |
// |               axis output was saturated in the error's direction.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pid_multi_axis #(
  parameter int N_AXES      = 3,
  parameter int IN_WIDTH    = 16,
  parameter int GAIN_WIDTH  = 16,
  parameter int GAIN_FRAC   = 8,
  parameter int INTEG_WIDTH = 24,
  parameter int INTEG_LIMIT = 2**20,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         clear_integ,
  input  logic [N_AXES*IN_WIDTH-1:0]   target_rate,
  input  logic [N_AXES*IN_WIDTH-1:0]   actual_rate,
  input  logic [N_AXES*GAIN_WIDTH-1:0] kp,
  input  logic [N_AXES*GAIN_WIDTH-1:0] ki,
  input  logic [N_AXES*GAIN_WIDTH-1:0] kd,
  output logic [N_AXES*OUT_WIDTH-1:0]  rate_out,
  output logic [N_AXES-1:0]            sat_flags,
  output logic                         busy,
  output logic                         done
);

  localparam int c_err_w = IN_WIDTH + 1;
  localparam int c_der_w = IN_WIDTH + 2;
  localparam int c_p_w   = GAIN_WIDTH + c_err_w;
  localparam int c_i_w   = GAIN_WIDTH + INTEG_WIDTH;
  localparam int c_d_w   = GAIN_WIDTH + c_der_w;
  localparam int c_acc_w = GAIN_WIDTH + INTEG_WIDTH + 2;
  localparam int c_ax_w  = (N_AXES > 1) ? $clog2(N_AXES) : 1;

  localparam logic signed [INTEG_WIDTH:0] c_lim_pos = (INTEG_WIDTH+1)'(INTEG_LIMIT);
  localparam logic signed [INTEG_WIDTH:0] c_lim_neg = -c_lim_pos;
  localparam logic signed [c_acc_w-1:0]   c_out_max = c_acc_w'((2**(OUT_WIDTH-1)) - 1);
  localparam logic signed [c_acc_w-1:0]   c_out_min = -c_out_max - c_acc_w'(1);
  localparam logic [c_ax_w-1:0]           c_last    = c_ax_w'(N_AXES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INTEG = 3'd2,
    ST_MULT  = 3'd3,
    ST_SUM   = 3'd4,
    ST_SAT   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t r_state, w_state_nxt;
  logic [c_ax_w-1:0] r_axis;

  // Input snapshot taken at start-accept, so inputs may move during a run
  logic signed [IN_WIDTH-1:0]    r_tgt   [N_AXES];
  logic signed [IN_WIDTH-1:0]    r_act   [N_AXES];
  logic signed [GAIN_WIDTH-1:0]  r_kp    [N_AXES];
  logic signed [GAIN_WIDTH-1:0]  r_ki    [N_AXES];
  logic signed [GAIN_WIDTH-1:0]  r_kd    [N_AXES];
  // Per-axis persistent state
  logic signed [INTEG_WIDTH-1:0] r_integ [N_AXES];
  logic signed [c_err_w-1:0]     r_prev  [N_AXES];
  logic signed [OUT_WIDTH-1:0]   r_shadow[N_AXES];
  logic                          r_sat_sh[N_AXES];
  logic signed [OUT_WIDTH-1:0]   r_rate  [N_AXES];
  logic [N_AXES-1:0]             r_sat_flags;
  // Shared pipeline registers
  logic signed [c_err_w-1:0]     r_err;
  logic signed [INTEG_WIDTH-1:0] r_integ_new;
  logic signed [c_der_w-1:0]     r_deriv;
  logic signed [c_p_w-1:0]       r_p;
  logic signed [c_i_w-1:0]       r_i;
  logic signed [c_d_w-1:0]       r_d;
  logic signed [c_acc_w-1:0]     r_sum;

  logic w_accept, w_clear;
  assign w_clear  = (r_state == ST_IDLE) && clear_integ;
  assign w_accept = (r_state == ST_IDLE) && start && !clear_integ;

  // LOAD: error of the current axis, one extra bit so it cannot overflow
  logic signed [IN_WIDTH-1:0] w_tgt, w_act;
  logic signed [c_err_w-1:0]  w_err;
  assign w_tgt = r_tgt[r_axis];
  assign w_act = r_act[r_axis];
  assign w_err = $signed({w_tgt[IN_WIDTH-1], w_tgt}) - $signed({w_act[IN_WIDTH-1], w_act});

  // INTEG: saturating integrator update and derivative term
  logic signed [INTEG_WIDTH-1:0] w_integ_cur, w_integ_clamped, w_integ_next;
  logic signed [INTEG_WIDTH:0]   w_integ_sum;
  logic signed [c_err_w-1:0]     w_prev_cur;
  logic signed [c_der_w-1:0]     w_deriv;
  assign w_integ_cur = r_integ[r_axis];
  assign w_prev_cur  = r_prev[r_axis];
  assign w_integ_sum = $signed({w_integ_cur[INTEG_WIDTH-1], w_integ_cur})
                     + $signed({{(INTEG_WIDTH+1-c_err_w){r_err[c_err_w-1]}}, r_err});
  assign w_deriv     = $signed({r_err[c_err_w-1], r_err})
                     - $signed({w_prev_cur[c_err_w-1], w_prev_cur});

  always_comb begin
    w_integ_clamped = w_integ_sum[INTEG_WIDTH-1:0];
    if (w_integ_sum > c_lim_pos)
      w_integ_clamped = c_lim_pos[INTEG_WIDTH-1:0];
    else if (w_integ_sum < c_lim_neg)
      w_integ_clamped = c_lim_neg[INTEG_WIDTH-1:0];
  end

`ifdef PID_ANTIWINDUP_EN
  // Saturation direction is recovered from the sign of the clamped shadow value
  logic w_err_pos, w_err_neg, w_hold;
  assign w_err_pos    = !r_err[c_err_w-1] && (r_err != '0);
  assign w_err_neg    = r_err[c_err_w-1];
  assign w_hold       = r_sat_sh[r_axis] &&
                        ((!r_shadow[r_axis][OUT_WIDTH-1] && w_err_pos) ||
                         ( r_shadow[r_axis][OUT_WIDTH-1] && w_err_neg));
  assign w_integ_next = w_hold ? w_integ_cur : w_integ_clamped;
`else
  assign w_integ_next = w_integ_clamped;
`endif

  // MULT: operands sign-extended to product width so the low bits are exact
  logic signed [GAIN_WIDTH-1:0] w_kp, w_ki, w_kd;
  logic signed [c_p_w-1:0] w_kp_x, w_err_x;
  logic signed [c_i_w-1:0] w_ki_x, w_int_x;
  logic signed [c_d_w-1:0] w_kd_x, w_der_x;
  assign w_kp    = r_kp[r_axis];
  assign w_ki    = r_ki[r_axis];
  assign w_kd    = r_kd[r_axis];
  assign w_kp_x  = {{c_err_w{w_kp[GAIN_WIDTH-1]}}, w_kp};
  assign w_err_x = {{GAIN_WIDTH{r_err[c_err_w-1]}}, r_err};
  assign w_ki_x  = {{INTEG_WIDTH{w_ki[GAIN_WIDTH-1]}}, w_ki};
  assign w_int_x = {{GAIN_WIDTH{r_integ_new[INTEG_WIDTH-1]}}, r_integ_new};
  assign w_kd_x  = {{c_der_w{w_kd[GAIN_WIDTH-1]}}, w_kd};
  assign w_der_x = {{GAIN_WIDTH{r_deriv[c_der_w-1]}}, r_deriv};

  // SUM: wide enough that P+I+D never wraps
  logic signed [c_acc_w-1:0] w_acc;
  assign w_acc = $signed({{(c_acc_w-c_p_w){r_p[c_p_w-1]}}, r_p})
               + $signed({{(c_acc_w-c_i_w){r_i[c_i_w-1]}}, r_i})
               + $signed({{(c_acc_w-c_d_w){r_d[c_d_w-1]}}, r_d});

  // SAT: output clamp
  logic                        w_sat_hi, w_sat_lo, w_sat;
  logic signed [OUT_WIDTH-1:0] w_sat_val;
  assign w_sat_hi  = r_sum > c_out_max;
  assign w_sat_lo  = r_sum < c_out_min;
  assign w_sat     = w_sat_hi || w_sat_lo;
  assign w_sat_val = w_sat_hi ? c_out_max[OUT_WIDTH-1:0] :
                     w_sat_lo ? c_out_min[OUT_WIDTH-1:0] : r_sum[OUT_WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_INTEG;
      ST_INTEG: w_state_nxt = ST_MULT;
      ST_MULT:  w_state_nxt = ST_SUM;
      ST_SUM:   w_state_nxt = ST_SAT;
      ST_SAT:   w_state_nxt = (r_axis == c_last) ? ST_DONE : ST_LOAD;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_axis      <= '0;
      r_err       <= '0;
      r_integ_new <= '0;
      r_deriv     <= '0;
      r_p         <= '0;
      r_i         <= '0;
      r_d         <= '0;
      r_sum       <= '0;
      r_sat_flags <= '0;
      for (int a = 0; a < N_AXES; a++) begin
        r_tgt[a]    <= '0;
        r_act[a]    <= '0;
        r_kp[a]     <= '0;
        r_ki[a]     <= '0;
        r_kd[a]     <= '0;
        r_integ[a]  <= '0;
        r_prev[a]   <= '0;
        r_shadow[a] <= '0;
        r_sat_sh[a] <= 1'b0;
        r_rate[a]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_clear) begin
            for (int a = 0; a < N_AXES; a++) begin
              r_integ[a]  <= '0;
              r_prev[a]   <= '0;
              r_sat_sh[a] <= 1'b0;
            end
          end else if (w_accept) begin
            r_axis <= '0;
            for (int a = 0; a < N_AXES; a++) begin
              r_tgt[a] <= target_rate[a*IN_WIDTH +: IN_WIDTH];
              r_act[a] <= actual_rate[a*IN_WIDTH +: IN_WIDTH];
              r_kp[a]  <= kp[a*GAIN_WIDTH +: GAIN_WIDTH];
              r_ki[a]  <= ki[a*GAIN_WIDTH +: GAIN_WIDTH];
              r_kd[a]  <= kd[a*GAIN_WIDTH +: GAIN_WIDTH];
            end
          end
        end
        ST_LOAD: r_err <= w_err;
        ST_INTEG: begin
          r_integ_new <= w_integ_next;
          r_deriv     <= w_deriv;
        end
        ST_MULT: begin
          r_p <= w_kp_x * w_err_x;
          r_i <= w_ki_x * w_int_x;
          r_d <= w_kd_x * w_der_x;
        end
        ST_SUM: r_sum <= w_acc >>> GAIN_FRAC;
        ST_SAT: begin
          r_shadow[r_axis] <= w_sat_val;
          r_sat_sh[r_axis] <= w_sat;
          r_prev[r_axis]   <= r_err;
          r_integ[r_axis]  <= r_integ_new;
          if (r_axis == c_last) begin
            // Publish all axes on the edge entering DONE; the last axis bypasses its shadow
            for (int a = 0; a < N_AXES; a++) begin
              r_rate[a]      <= (c_ax_w'(a) == r_axis) ? w_sat_val : r_shadow[a];
              r_sat_flags[a] <= (c_ax_w'(a) == r_axis) ? w_sat : r_sat_sh[a];
            end
          end else begin
            r_axis <= r_axis + c_ax_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_AXES; g++) begin : g_out
    assign rate_out[g*OUT_WIDTH +: OUT_WIDTH] = r_rate[g];
  end

  assign sat_flags = r_sat_flags;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pid_multi_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pid_multi_axis                                            |
// | Description : Directed self-checking bench for pid_multi_axis. A second    |
// |               instance with INTEG_LIMIT=1000 shares the stimulus for the   |
// |               integrator clamp case.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pid_multi_axis;
  localparam int N  = 3;
  localparam int IW = 16;
  localparam int GW = 16;
  localparam int OW = 16;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic clear_integ = 1'b0;
  logic [N*IW-1:0] target_rate = '0;
  logic [N*IW-1:0] actual_rate = '0;
  logic [N*GW-1:0] kp = '0;
  logic [N*GW-1:0] ki = '0;
  logic [N*GW-1:0] kd = '0;
  logic [N*OW-1:0] rate_out, rate_out_l;
  logic [N-1:0]    sat_flags, sat_flags_l;
  logic            busy, busy_l, done, done_l;

  pid_multi_axis dut (
    .us_clk(us_clk), .resetn(resetn), .start(start), .clear_integ(clear_integ),
    .target_rate(target_rate), .actual_rate(actual_rate), .kp(kp), .ki(ki), .kd(kd),
    .rate_out(rate_out), .sat_flags(sat_flags), .busy(busy), .done(done)
  );

  pid_multi_axis #(.INTEG_LIMIT(1000)) dut_lim (
    .us_clk(us_clk), .resetn(resetn), .start(start), .clear_integ(clear_integ),
    .target_rate(target_rate), .actual_rate(actual_rate), .kp(kp), .ki(ki), .kd(kd),
    .rate_out(rate_out_l), .sat_flags(sat_flags_l), .busy(busy_l), .done(done_l)
  );

  always #5 us_clk = ~us_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] rout(input int a);
    logic signed [OW-1:0] v;
    v = rate_out[a*OW +: OW];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] rout_l(input int a);
    logic signed [OW-1:0] v;
    v = rate_out_l[a*OW +: OW];
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  task automatic zero_all();
    target_rate = '0; actual_rate = '0; kp = '0; ki = '0; kd = '0;
  endtask

  task automatic set_axis(input int a, input int t, input int act,
                          input int p, input int i, input int d);
    target_rate[a*IW +: IW] = IW'(t);
    actual_rate[a*IW +: IW] = IW'(act);
    kp[a*GW +: GW] = GW'(p);
    ki[a*GW +: GW] = GW'(i);
    kd[a*GW +: GW] = GW'(d);
  endtask

  task automatic clear();
    clear_integ = 1'b1;
    tick();
    clear_integ = 1'b0;
  endtask

  // Accepts a start and returns the edge count (after edge 0) at which done was seen
  task automatic run(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    tick();
  endtask

  task automatic run_chk(input string tag);
    int lat;
    run(lat);
    check({tag, "_latency"}, lat, 15);
  endtask

  initial begin
    int lat;
    int ndone;
    zero_all();
    repeat (3) tick();
    check("reset_rate0", rout(0), 0);
    check("reset_rate1", rout(1), 0);
    check("reset_sat", 32'(sat_flags), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    @(negedge us_clk);
    resetn = 1'b1;
    tick();

    // Proportional only, with detailed handshake timing
    set_axis(0, 100, 40, 'h100, 0, 0);
    set_axis(1, -50, 50, 'h100, 0, 0);
    set_axis(2, 0, 0, 'h100, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("prop_busy_edge0", 32'(busy), 1);
    target_rate = '1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    check("prop_done_edge", lat, 15);
    check("prop_busy_in_done", 32'(busy), 1);
    check("prop_r0", rout(0), 60);
    check("prop_r1", rout(1), -100);
    check("prop_r2", rout(2), 0);
    check("prop_sat", 32'(sat_flags), 0);
    tick();
    check("prop_busy_after", 32'(busy), 0);
    check("prop_done_after", 32'(done), 0);
    check("prop_r1_hold", rout(1), -100);

    // Output saturation both directions
    zero_all();
    set_axis(0, 1000, 0, 'h7FFF, 0, 0);
    run_chk("satp");
    check("satp_r0", rout(0), 32767);
    check("satp_flags", 32'(sat_flags), 1);
    set_axis(0, -1000, 0, 'h7FFF, 0, 0);
    run_chk("satn");
    check("satn_r0", rout(0), -32768);
    check("satn_flags", 32'(sat_flags), 1);

    // Integrator on axis 1
    zero_all();
    clear();
    set_axis(1, 10, 0, 0, 'h100, 0);
    run_chk("int1"); check("int_run1", rout(1), 10);
    run_chk("int2"); check("int_run2", rout(1), 20);
    run_chk("int3"); check("int_run3", rout(1), 30);
    check("int_sat", 32'(sat_flags), 0);
    clear();
    check("clear_keeps_rate", rout(1), 30);
    run_chk("int4"); check("int_after_clear", rout(1), 10);

    // Derivative on axis 1
    zero_all();
    clear();
    set_axis(1, 10, 0, 0, 0, 'h100);
    run_chk("der1"); check("der_run1", rout(1), 10);
    set_axis(1, 25, 0, 0, 0, 'h100);
    run_chk("der2"); check("der_run2", rout(1), 15);

    // Integrator clamp (limit 1000 instance)
    zero_all();
    clear();
    set_axis(1, 600, 0, 0, 'h100, 0);
    run_chk("clmp1"); check("clamp_run1", rout_l(1), 600);
    run_chk("clmp2"); check("clamp_run2", rout_l(1), 1000);
    run_chk("clmp3"); check("clamp_run3", rout_l(1), 1000);
    check("clamp_unlimited", rout(1), 1800);

    // start together with clear_integ: clear wins
    zero_all();
    clear();
    set_axis(1, 10, 0, 0, 'h100, 0);
    run_chk("sc1"); check("sc_prime", rout(1), 10);
    start = 1'b1; clear_integ = 1'b1;
    tick();
    start = 1'b0; clear_integ = 1'b0;
    check("sc_no_busy", 32'(busy), 0);
    tick();
    check("sc_still_idle", 32'(busy), 0);
    set_axis(1, 0, 0, 0, 'h100, 0);
    run_chk("sc2"); check("sc_integ_zero", rout(1), 0);

    // start held through a run: exactly one done
    zero_all();
    set_axis(0, 5, 0, 'h100, 0, 0);
    start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) begin
        ndone++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_start_dones", ndone, 1);
    check("held_start_r0", rout(0), 5);

    // Reset during MULT aborts the run
    zero_all();
    set_axis(0, 100, 40, 'h100, 0, 0);
    set_axis(1, -50, 50, 'h100, 0, 0);
    run_chk("rst_pre"); check("rst_pre_r0", rout(0), 60);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("rst_r0", rout(0), 0);
    check("rst_r1", rout(1), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge us_clk);
    resetn = 1'b1;
    tick();
    run_chk("rst_post");
    check("rst_post_r0", rout(0), 60);
    check("rst_post_r1", rout(1), -100);

    // Anti-windup: integrator observed afterwards with kp=0 and zero error
    zero_all();
    clear();
    set_axis(0, 1000, 0, 'h7FFF, 'h100, 0);
    run_chk("aw1"); check("aw_run1", rout(0), 32767);
    run_chk("aw2"); check("aw_run2", rout(0), 32767);
    run_chk("aw3"); check("aw_run3", rout(0), 32767);
    set_axis(0, 0, 0, 0, 'h100, 0);
    run_chk("aw4");
`ifdef PID_ANTIWINDUP_EN
    check("aw_integ", rout(0), 1000);
`else
    check("aw_integ", rout(0), 3000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
